ntt_sequencer: RTL and testbench
================================

// Module: ntt_sequencer
// PURPOSE
// - Drives one ntt_core through a full transform: issues log_m, i and mode for every butterfly stage, then sweeps read_address for readout.
// - Sits between the host start/done handshake and the ntt_core control inputs.
// - Coefficient loading (write_enable, write addresses and data) stays with the host; this block never drives it.
// PARAMETERS
// - LOG_N           12   log2 transform length; number of stages.
// - LOG_CORE_COUNT  5    log2 cores sharing the transform.
// - ITER_COUNT      64   butterfly issues per stage per core; must equal 2**(LOG_N-1-LOG_CORE_COUNT).
// - PIPE_LATENCY    4    hold cycles after each stage so the core pipeline drains; must be >=1.
// - READ_DEPTH      512  words swept in readout; must be <=512.
// PORTS
// - clk           in   1   clock, rising edge.
// - rst_n         in   1   asynchronous active-low reset.
// - start         in   1   begin transform; sampled only in IDLE.
// - inverse       in   1   latched with start: 0 = forward NTT, 1 = inverse.
// - abort         in   1   return to IDLE; no done pulse.
// - busy          out  1   high in every state except IDLE.
// - done          out  1   one-cycle pulse at end of readout.
// - log_m         out  4   stage index to ntt_core.
// - i             out  10  butterfly index to ntt_core.
// - mode          out  2   0 = NTT butterfly, 1 = INTT butterfly, 2 = hold, 3 = readout.
// - read_address  out  9   ntt_core read address.
// - rd_valid      out  1   r1..r4 valid this cycle (core read latency is 1).
// BEHAVIOUR
// - Reset is asynchronous and active-low; clock is clk. All outputs are registered.
// - Reset values: busy=0, done=0, log_m=0, i=0, mode=2, read_address=0, rd_valid=0. State is IDLE.
// - IDLE:
//   - Outputs hold their reset values.
//   - start=1 latches inverse, sets i=0, sets log_m (1 if forward, LOG_N if inverse) and moves to COMPUTE.
// - COMPUTE:
//   - mode = inverse ? 1 : 0.
//   - i increments each cycle.
//   - When i==ITER_COUNT-1, the next state is DRAIN with drain counter 0.
// - DRAIN:
//   - mode=2; log_m and i hold; the drain counter increments each cycle.
//   - When the counter reaches PIPE_LATENCY-1:
//     - if the last stage is done (forward log_m==LOG_N, inverse log_m==1), go to READOUT with read_address=0;
//     - otherwise step log_m (+1 forward, -1 inverse), set i=0 and return to COMPUTE.
// - READOUT:
//   - mode=3; read_address increments each cycle.
//   - rd_valid is read_address-issued delayed by 1 cycle.
//   - When read_address==READ_DEPTH-1, go to DONE.
// - DONE:
//   - Lasts one cycle: done=1, mode=2, rd_valid=1 (last word); then IDLE.
// - Cycle counts:
//   - busy lasts LOG_N*(ITER_COUNT+PIPE_LATENCY)+READ_DEPTH+1 cycles;
//   - done is on the last of those cycles.
// - start while busy: ignored; inverse is not re-latched.
// - abort has priority over all transitions, including start in the same cycle:
//   - next cycle the state is IDLE and all outputs return to their reset values;
//   - rd_valid drops immediately; no done pulse.
// - start and abort in IDLE together: stay IDLE.
// - Counters never wrap. i is 10 bits (max 1023); read_address is 9 bits (max 511).
// - rst_n low mid-transform: immediate return to IDLE with reset values; the latched inverse is cleared.
// CONFIGURATION
// - NTT_SEQ_CYCLE_COUNT_EN defined:
//   - adds output cycle_count (32 bits);
//   - it clears on accepted start and increments every busy cycle;
//   - it holds its value after done or abort until the next start;
//   - it resets to 0.
// - NTT_SEQ_CYCLE_COUNT_EN undefined: no port, no counter logic; all other behaviour is identical.
// TESTING
// - Use LOG_N=4, LOG_CORE_COUNT=1, ITER_COUNT=4, PIPE_LATENCY=2, READ_DEPTH=8.
// - Forward:
//   - stimulus: start=1, inverse=0 for one cycle;
//   - response: log_m steps 1,2,3,4; i runs 0..3 per stage with mode=0; 2 hold cycles (mode=2) after each stage;
//   - then mode=3 with read_address 0..7 and rd_valid 1 cycle behind;
//   - busy lasts 33 cycles; done=1 on the 33rd;
//   - with NTT_SEQ_CYCLE_COUNT_EN, cycle_count=33.
// - Inverse:
//   - stimulus: start=1, inverse=1;
//   - response: log_m steps 4,3,2,1 with mode=1; same timing; done after 33 cycles.
// - start ignored:
//   - stimulus: pulse start=1, inverse=1 at cycle 5 of a forward run;
//   - response: no restart; mode stays 0 in COMPUTE; done still at cycle 33.
// - abort:
//   - stimulus: abort=1 during READOUT at read_address=3;
//   - response: next cycle busy=0, mode=2, read_address=0, rd_valid=0; no done pulse;
//   - a following start runs a full 33-cycle transform.
// - Reset:
//   - stimulus: rst_n=0 asynchronously mid-DRAIN of stage 2;
//   - response: outputs at reset values before the next clk edge;
//   - after release, IDLE until start.
// - start and abort together in IDLE -> remains IDLE, busy=0.

Source files
------------

// File: rtl/ntt_sequencer.sv
// Stage/index/mode sequencer for one ntt_core transform plus readout sweep.
// Optional NTT_SEQ_CYCLE_COUNT_EN adds a 32-bit busy-cycle counter output.
module ntt_sequencer #(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 5,
  parameter int ITER_COUNT     = 64,
  parameter int PIPE_LATENCY   = 4,
  parameter int READ_DEPTH     = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        inverse,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  log_m,
  output logic [9:0]  i,
  output logic [1:0]  mode,
  output logic [8:0]  read_address,
`ifdef NTT_SEQ_CYCLE_COUNT_EN
  output logic [31:0] cycle_count,
`endif
  output logic        rd_valid
);

  localparam int DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPUTE = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_READOUT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [9:0]    I_LAST = 10'(ITER_COUNT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LATENCY - 1);
  localparam logic [8:0]    A_LAST = 9'(READ_DEPTH - 1);
  localparam logic [3:0]    M_TOP  = 4'(LOG_N);

  if (ITER_COUNT != 2 ** (LOG_N - 1 - LOG_CORE_COUNT)) begin : g_chk
    $error("ITER_COUNT inconsistent with LOG_N/LOG_CORE_COUNT");
  end

  logic [2:0]    r_state;
  logic          r_inv;
  logic [DW-1:0] r_dcnt;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_log_m;
  logic [9:0]    r_i;
  logic [1:0]    r_mode;
  logic [8:0]    r_addr;
  logic          r_rdv;
  logic          w_last_stage;

  assign w_last_stage = r_inv ? (r_log_m == 4'd1) : (r_log_m == M_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_inv   <= 1'b0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_log_m <= 4'd0;
      r_i     <= 10'd0;
      r_mode  <= 2'd2;
      r_addr  <= 9'd0;
      r_rdv   <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_inv   <= 1'b0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_log_m <= 4'd0;
      r_i     <= 10'd0;
      r_mode  <= 2'd2;
      r_addr  <= 9'd0;
      r_rdv   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_COMPUTE;
            r_inv   <= inverse;
            r_i     <= 10'd0;
            r_log_m <= inverse ? M_TOP : 4'd1;
            r_mode  <= {1'b0, inverse};
            r_busy  <= 1'b1;
          end
        end
        S_COMPUTE: begin
          if (r_i == I_LAST) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
            r_mode  <= 2'd2;
          end else begin
            r_i <= r_i + 10'd1;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == D_LAST) begin
            if (w_last_stage) begin
              r_state <= S_READOUT;
              r_mode  <= 2'd3;
              r_addr  <= 9'd0;
            end else begin
              r_state <= S_COMPUTE;
              r_log_m <= r_inv ? r_log_m - 4'd1 : r_log_m + 4'd1;
              r_i     <= 10'd0;
              r_mode  <= {1'b0, r_inv};
            end
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        S_READOUT: begin
          // core read latency is one cycle, so valid trails the address
          r_rdv <= 1'b1;
          if (r_addr == A_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_mode  <= 2'd2;
          end else begin
            r_addr <= r_addr + 9'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_inv   <= 1'b0;
          r_dcnt  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_log_m <= 4'd0;
          r_i     <= 10'd0;
          r_mode  <= 2'd2;
          r_addr  <= 9'd0;
          r_rdv   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NTT_SEQ_CYCLE_COUNT_EN
  logic [31:0] r_ccnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ccnt <= 32'd0;
    end else if (r_state == S_IDLE && start && !abort) begin
      r_ccnt <= 32'd0;
    end else if (r_busy) begin
      r_ccnt <= r_ccnt + 32'd1;
    end
  end

  assign cycle_count = r_ccnt;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign log_m        = r_log_m;
  assign i            = r_i;
  assign mode         = r_mode;
  assign read_address = r_addr;
  assign rd_valid     = r_rdv;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Directed bench for ntt_sequencer with a 16-point, 2-core setup.
// Expected waveforms come from a closed-form cycle schedule.
module tb_ntt_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        inverse;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  log_m;
  logic [9:0]  idx;
  logic [1:0]  mode;
  logic [8:0]  read_address;
  logic        rd_valid;
`ifdef NTT_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  ntt_sequencer #(
    .LOG_N(4),
    .LOG_CORE_COUNT(1),
    .ITER_COUNT(4),
    .PIPE_LATENCY(2),
    .READ_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .inverse(inverse),
    .abort(abort),
    .busy(busy),
    .done(done),
    .log_m(log_m),
    .i(idx),
    .mode(mode),
    .read_address(read_address),
`ifdef NTT_SEQ_CYCLE_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".log_m"}, 32'(log_m), 32'd0);
    chk({tag, ".i"}, 32'(idx), 32'd0);
    chk({tag, ".mode"}, 32'(mode), 32'd2);
    chk({tag, ".addr"}, 32'(read_address), 32'd0);
    chk({tag, ".rdv"}, 32'(rd_valid), 32'd0);
  endtask

  // c counts busy cycles from 0; 4 stages of 4 compute + 2 hold,
  // then 8 readout cycles, then the done cycle at c==32.
  task automatic run(input string tag, input logic inv,
                     input int pulse_at, input int abort_at);
    logic [3:0] e_m;
    logic [9:0] e_i;
    logic [1:0] e_mode;
    logic [8:0] e_a;
    logic       e_v;
    logic       e_d;
    int         st;
    int         off;
    start = 1'b1;
    inverse = inv;
    tick();
    start = 1'b0;
    inverse = 1'b0;
    for (int c = 0; c < 33; c++) begin
      e_d = 1'b0;
      e_v = 1'b0;
      e_a = 9'd0;
      if (c < 24) begin
        st = c / 6;
        off = c % 6;
        e_m = inv ? 4'(4 - st) : 4'(st + 1);
        e_i = (off < 4) ? 10'(off) : 10'd3;
        e_mode = (off < 4) ? {1'b0, inv} : 2'd2;
      end else begin
        e_m = inv ? 4'd1 : 4'd4;
        e_i = 10'd3;
        if (c < 32) begin
          e_mode = 2'd3;
          e_a = 9'(c - 24);
          e_v = (c > 24);
        end else begin
          e_mode = 2'd2;
          e_a = 9'd7;
          e_v = 1'b1;
          e_d = 1'b1;
        end
      end
      chk($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s.c%0d.done", tag, c), 32'(done), 32'(e_d));
      chk($sformatf("%s.c%0d.log_m", tag, c), 32'(log_m), 32'(e_m));
      chk($sformatf("%s.c%0d.i", tag, c), 32'(idx), 32'(e_i));
      chk($sformatf("%s.c%0d.mode", tag, c), 32'(mode), 32'(e_mode));
      chk($sformatf("%s.c%0d.addr", tag, c), 32'(read_address), 32'(e_a));
      chk($sformatf("%s.c%0d.rdv", tag, c), 32'(rd_valid), 32'(e_v));
      if (c == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle({tag, ".abort"});
        for (int k = 0; k < 3; k++) begin
          tick();
          chk({tag, ".post_abort.done"}, 32'(done), 32'd0);
        end
`ifdef NTT_SEQ_CYCLE_COUNT_EN
        chk({tag, ".abort.ccnt"}, cycle_count, 32'(c + 1));
`endif
        return;
      end
      start = (c == pulse_at);
      inverse = (c == pulse_at);
      tick();
      start = 1'b0;
      inverse = 1'b0;
    end
    chk_idle({tag, ".end"});
`ifdef NTT_SEQ_CYCLE_COUNT_EN
    chk({tag, ".ccnt"}, cycle_count, 32'd33);
`endif
    tick();
    chk({tag, ".idle2.busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    inverse = 1'b0;
    abort = 1'b0;
    #12;
    chk_idle("reset");
`ifdef NTT_SEQ_CYCLE_COUNT_EN
    chk("reset.ccnt", cycle_count, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle("idle");

    run("fwd", 1'b0, -1, -1);
    run("inv", 1'b1, -1, -1);
    run("ign", 1'b0, 5, -1);
    run("abort", 1'b0, -1, 27);
    run("refwd", 1'b0, -1, -1);

    // async reset during the second hold cycle of stage 2
    start = 1'b1;
    inverse = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    chk("rst.pre.mode", 32'(mode), 32'd2);
    chk("rst.pre.log_m", 32'(log_m), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("rst.async");
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst.after.busy", 32'(busy), 32'd0);
    end

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start_abort");
    tick();
    chk("start_abort.next.busy", 32'(busy), 32'd0);

    run("post_rst", 1'b1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
